// File: rtl/alu_serial_ctrl_if.sv
// Handshake and operand/result bundle for the bit-serial ALU sequencer.
interface alu_serial_ctrl_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic             ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       ctrl;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;
    logic             done;

    // Requester side: issues operations, observes completion
    modport master (
        output start, a, b, ctrl,
        input  ready, result, zero, overflow, done
    );

    // ALU side: accepts operations, reports completion
    modport slave (
        input  start, a, b, ctrl,
        output ready, result, zero, overflow, done
    );
endinterface

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU sequencer: one bit per clock, LSB first, carry/borrow flop.
// Optional feature macro: ALU_SERIAL_LOGIC_BYPASS_EN evaluates logic codes
// in parallel and skips the serial RUN phase for them.
module alu_serial_ctrl #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_serial_ctrl_if.slave   bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_DONE = 2'b10;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOR = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    // Single-bit logic function; unused code 011 yields 0
    function automatic logic logic_bit(input logic [2:0] op, input logic ai, input logic bi);
        case (op)
            OP_AND:  logic_bit = ai & bi;
            OP_OR:   logic_bit = ai | bi;
            OP_XOR:  logic_bit = ai ^ bi;
            OP_NOR:  logic_bit = ~(ai | bi);
            default: logic_bit = 1'b0;
        endcase
    endfunction

    logic [1:0]       state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             carry_q,  carry_d;
    logic [WIDTH-1:0] a_sr_q,   a_sr_d;
    logic [WIDTH-1:0] b_sr_q,   b_sr_d;
    logic [WIDTH-1:0] res_sr_q, res_sr_d;
    logic [2:0]       ctrl_q,   ctrl_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q,   zero_d;
    logic             ovf_q,    ovf_d;
    logic             done_q,   done_d;
    logic             ready_q,  ready_d;

    logic             is_sub;
    logic             is_arith;
    logic             b_bit;
    logic             sum_bit;
    logic             carry_out;
    logic             res_bit;
    logic             msb_ovf;
    logic [WIDTH-1:0] res_shift;
    logic [WIDTH-1:0] fin_res;
`ifdef ALU_SERIAL_LOGIC_BYPASS_EN
    logic [WIDTH-1:0] par_res;
    logic             in_logic;
`endif

    // State register and datapath flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_sr_q <= '0;
            ctrl_q   <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_sr_q <= res_sr_d;
            ctrl_q   <= ctrl_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
        end
    end

    // Next-state, per-bit evaluation and output load
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_sr_d = res_sr_q;
        ctrl_d   = ctrl_q;
        result_d = result_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;

        is_sub    = (ctrl_q == OP_SUB) || (ctrl_q == OP_SLT);
        is_arith  = is_sub || (ctrl_q == OP_ADD);
        b_bit     = b_sr_q[0] ^ is_sub;
        sum_bit   = a_sr_q[0] ^ b_bit ^ carry_q;
        carry_out = (a_sr_q[0] & b_bit) | (a_sr_q[0] & carry_q) | (b_bit & carry_q);
        res_bit   = is_arith ? sum_bit : logic_bit(ctrl_q, a_sr_q[0], b_sr_q[0]);
        res_shift = {res_bit, res_sr_q[WIDTH-1:1]};
        msb_ovf   = is_arith & (carry_q ^ carry_out);
        fin_res   = (ctrl_q == OP_SLT) ? WIDTH'(sum_bit ^ msb_ovf) : res_shift;

`ifdef ALU_SERIAL_LOGIC_BYPASS_EN
        for (int i = 0; i < int'(WIDTH); i++) begin
            par_res[i] = logic_bit(bus.ctrl, bus.a[i], bus.b[i]);
        end
        in_logic = !((bus.ctrl == OP_ADD) || (bus.ctrl == OP_SUB) || (bus.ctrl == OP_SLT));
`endif

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_sr_d   = bus.a;
                    b_sr_d   = bus.b;
                    ctrl_d   = bus.ctrl;
                    carry_d  = (bus.ctrl == OP_SUB) || (bus.ctrl == OP_SLT);
                    cnt_d    = '0;
                    res_sr_d = '0;
                    state_d  = S_RUN;
`ifdef ALU_SERIAL_LOGIC_BYPASS_EN
                    if (in_logic) begin
                        state_d  = S_DONE;
                        result_d = par_res;
                        zero_d   = (par_res == '0);
                        ovf_d    = 1'b0;
                        done_d   = 1'b1;
                    end
`endif
                end
            end
            S_RUN: begin
                a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
                res_sr_d = res_shift;
                carry_d  = carry_out;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d  = S_DONE;
                    cnt_d    = '0;
                    carry_d  = 1'b0;
                    result_d = fin_res;
                    zero_d   = (fin_res == '0);
                    ovf_d    = (ctrl_q == OP_SLT) ? 1'b0 : msb_ovf;
                    done_d   = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ready_d = (state_d == S_IDLE);
    end

    assign bus.ready    = ready_q;
    assign bus.result   = result_q;
    assign bus.zero     = zero_q;
    assign bus.overflow = ovf_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Directed self-checking bench for alu_serial_ctrl (WIDTH = 32).
module tb_alu_serial_ctrl;
    localparam int unsigned W = 32;
`ifdef ALU_SERIAL_LOGIC_BYPASS_EN
    localparam int LOGIC_LAT = 1;
`else
    localparam int LOGIC_LAT = 33;
`endif

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    alu_serial_ctrl_if #(.WIDTH(W)) bus ();

    alu_serial_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one op from an idle point (#1 after posedge, ready=1); latency counts the accept edge
    task automatic do_op(input logic [31:0] ia, input logic [31:0] ib, input logic [2:0] ic,
                         output logic [31:0] r, output logic z, output logic ov, output int lat);
        bus.a = ia; bus.b = ib; bus.ctrl = ic; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 1;
        while (bus.done !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        r = bus.result; z = bus.zero; ov = bus.overflow;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        n_checks++;
        if (bus.ready !== 1'b1 || bus.done !== 1'b0 || bus.result !== 32'h0 ||
            bus.zero !== 1'b0 || bus.overflow !== 1'b0) begin
            n_errors++;
            $display("FAIL reset: ready=%b done=%b result=%h zero=%b ovf=%b, need 1 0 0 0 0",
                     bus.ready, bus.done, bus.result, bus.zero, bus.overflow);
        end
    endtask

    task automatic test_add();
        logic [31:0] r; logic z, ov; int lat;
        do_op(32'h7FFF_FFFF, 32'h0000_0001, 3'b010, r, z, ov, lat);
        n_checks++;
        if (r !== 32'h8000_0000 || z !== 1'b0 || ov !== 1'b1) begin
            n_errors++;
            $display("FAIL add_ovf: got %h z=%b ov=%b, need 80000000 z=0 ov=1", r, z, ov);
        end
        n_checks++;
        if (lat !== 33) begin
            n_errors++;
            $display("FAIL add_latency: got %0d edges, need 33", lat);
        end
        n_checks++;
        if (bus.done !== 1'b0 || bus.ready !== 1'b1 || bus.result !== 32'h8000_0000) begin
            n_errors++;
            $display("FAIL done_pulse: done=%b ready=%b result=%h, need 0 1 80000000",
                     bus.done, bus.ready, bus.result);
        end
        do_op(32'hFFFF_FFFF, 32'h0000_0001, 3'b010, r, z, ov, lat);
        n_checks++;
        if (r !== 32'h0 || z !== 1'b1 || ov !== 1'b0) begin
            n_errors++;
            $display("FAIL add_wrap: got %h z=%b ov=%b, need 0 z=1 ov=0", r, z, ov);
        end
    endtask

    task automatic test_sub();
        logic [31:0] r; logic z, ov; int lat;
        do_op(32'd5, 32'd5, 3'b110, r, z, ov, lat);
        n_checks++;
        if (r !== 32'h0 || z !== 1'b1 || ov !== 1'b0) begin
            n_errors++;
            $display("FAIL sub_eq: got %h z=%b ov=%b, need 0 z=1 ov=0", r, z, ov);
        end
        do_op(32'h8000_0000, 32'd1, 3'b110, r, z, ov, lat);
        n_checks++;
        if (r !== 32'h7FFF_FFFF || z !== 1'b0 || ov !== 1'b1) begin
            n_errors++;
            $display("FAIL sub_ovf: got %h z=%b ov=%b, need 7fffffff z=0 ov=1", r, z, ov);
        end
    endtask

    task automatic test_slt();
        logic [31:0] r; logic z, ov; int lat;
        do_op(32'hFFFF_FFFF, 32'd1, 3'b111, r, z, ov, lat);
        n_checks++;
        if (r !== 32'd1 || z !== 1'b0 || ov !== 1'b0) begin
            n_errors++;
            $display("FAIL slt_neg: got %h z=%b ov=%b, need 1 z=0 ov=0", r, z, ov);
        end
        do_op(32'h7FFF_FFFF, 32'h8000_0000, 3'b111, r, z, ov, lat);
        n_checks++;
        if (r !== 32'd0 || z !== 1'b1 || ov !== 1'b0) begin
            n_errors++;
            $display("FAIL slt_ovf: got %h z=%b ov=%b, need 0 z=1 ov=0", r, z, ov);
        end
    endtask

    task automatic test_logic();
        logic [31:0] r; logic z, ov; int lat;
        logic [31:0] va [6];
        logic [31:0] vb [6];
        logic [2:0]  vc [6];
        logic [31:0] vr [6];
        va = '{32'hF0F0_F0F0, 32'h1234_5678, 32'hFFFF_FFFF, 32'hFF00_FF00, 32'hFF00_FF00, 32'hA5A5_0000};
        vb = '{32'h0F0F_0000, 32'h1234_5678, 32'hFFFF_FFFF, 32'h0FF0_0FF0, 32'h0FF0_0FF0, 32'h0000_5A5A};
        vc = '{3'b101,        3'b100,        3'b011,        3'b000,        3'b001,        3'b100};
        vr = '{32'h0000_0F0F, 32'h0,         32'h0,         32'h0F00_0F00, 32'hFFF0_FFF0, 32'hA5A5_5A5A};
        for (int i = 0; i < 6; i++) begin
            do_op(va[i], vb[i], vc[i], r, z, ov, lat);
            n_checks++;
            if (r !== vr[i] || z !== (vr[i] == 32'h0) || ov !== 1'b0) begin
                n_errors++;
                $display("FAIL logic_%0d ctrl=%b: got %h z=%b ov=%b, need %h z=%b ov=0",
                         i, vc[i], r, z, ov, vr[i], (vr[i] == 32'h0));
            end
            n_checks++;
            if (lat !== LOGIC_LAT) begin
                n_errors++;
                $display("FAIL logic_latency_%0d: got %0d edges, need %0d", i, lat, LOGIC_LAT);
            end
        end
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] r; logic z, ov; int lat;
        bit seen_done;
        bus.a = 32'h0000_1111; bus.b = 32'h0000_2222; bus.ctrl = 3'b010; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.ready !== 1'b1 || bus.done !== 1'b0 || bus.result !== 32'h0 ||
            bus.zero !== 1'b0 || bus.overflow !== 1'b0) begin
            n_errors++;
            $display("FAIL mid_reset: ready=%b done=%b result=%h zero=%b ovf=%b, need 1 0 0 0 0",
                     bus.ready, bus.done, bus.result, bus.zero, bus.overflow);
        end
        @(negedge clk) rst_n = 1'b1;
        seen_done = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) seen_done = 1'b1;
        end
        n_checks++;
        if (seen_done !== 1'b0 || bus.ready !== 1'b1) begin
            n_errors++;
            $display("FAIL abort_no_done: seen_done=%b ready=%b, need 0 1", seen_done, bus.ready);
        end
        do_op(32'd1, 32'd2, 3'b010, r, z, ov, lat);
        n_checks++;
        if (r !== 32'd3 || lat !== 33) begin
            n_errors++;
            $display("FAIL after_reset_op: got %h lat=%0d, need 3 lat=33", r, lat);
        end
    endtask

    task automatic test_ignore_start();
        int lat;
        bus.a = 32'd3; bus.b = 32'd4; bus.ctrl = 3'b010; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        bus.a = 32'd100; bus.b = 32'd200; bus.ctrl = 3'b110; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 7;
        while (bus.done !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        n_checks++;
        if (bus.result !== 32'd7 || lat !== 33) begin
            n_errors++;
            $display("FAIL ignore_start: got %h lat=%0d, need 7 lat=33", bus.result, lat);
        end
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (bus.ready !== 1'b1 || bus.result !== 32'd7) begin
            n_errors++;
            $display("FAIL no_queue: ready=%b result=%h, need 1 7", bus.ready, bus.result);
        end
    endtask

    task automatic test_back_to_back();
        int edge_n;
        int done_cnt;
        int t1, t2;
        logic [31:0] r1, r2;
        bus.a = 32'd10; bus.b = 32'd20; bus.ctrl = 3'b010; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.a = 32'd50; bus.b = 32'd8; bus.ctrl = 3'b110;
        edge_n = 1; done_cnt = 0; t1 = 0; t2 = 0; r1 = '0; r2 = '0;
        while (done_cnt < 2 && edge_n < 200) begin
            @(posedge clk); #1;
            edge_n++;
            if (bus.done === 1'b1) begin
                done_cnt++;
                if (done_cnt == 1) begin t1 = edge_n; r1 = bus.result; end
                else begin t2 = edge_n; r2 = bus.result; bus.start = 1'b0; end
            end
        end
        bus.start = 1'b0;
        n_checks++;
        if (r1 !== 32'd30 || t1 !== 33) begin
            n_errors++;
            $display("FAIL b2b_first: got %h at edge %0d, need 30 (0x1e) at 33", r1, t1);
        end
        n_checks++;
        if (r2 !== 32'd42 || (t2 - t1) !== 34) begin
            n_errors++;
            $display("FAIL b2b_second: got %h gap %0d, need 2a gap 34", r2, t2 - t1);
        end
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (bus.ready !== 1'b1 || bus.done !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_idle: ready=%b done=%b, need 1 0", bus.ready, bus.done);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.ctrl = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        test_add();
        test_sub();
        test_slt();
        test_logic();
        test_reset_mid_op();
        test_ignore_start();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
